// File: rtl/bsg_manycore_ruche_x_edge_adapter_pkg.sv
// Shared types and width/offset helpers for the ruche-X lane-0 edge adapter.
// Packet layout (LSB first): fwd = {dest_x, dest_y, src_x, src_y, ctrl+payload}; rev = {dest_x, dest_y, ctrl+payload}.
package bsg_manycore_ruche_x_edge_adapter_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   // op_v2(4) + reg_id(5) for fwd, pkt_type(2) + reg_id(5) for rev
   localparam int FWD_CTRL_WIDTH = 9;
   localparam int REV_CTRL_WIDTH = 7;

   function automatic int fwd_pkt_width(input int a, input int d, input int x, input int y);
      return a + d + FWD_CTRL_WIDTH + 2*x + 2*y;
   endfunction

   function automatic int rev_pkt_width(input int d, input int x, input int y);
      return d + REV_CTRL_WIDTH + x + y;
   endfunction

   function automatic int fwd_src_y_lsb(input int x, input int y);
      return 2*x + y;
   endfunction

   function automatic int rev_dest_y_lsb(input int x);
      return x;
   endfunction

   // link = {v, data, ready_and_rev}; link_sif = {fwd_link, rev_link}
   function automatic int link_sif_width(input int a, input int d, input int x, input int y);
      return fwd_pkt_width(a, d, x, y) + 2 + rev_pkt_width(d, x, y) + 2;
   endfunction

   function automatic int ruche_x_link_sif_width(input int a, input int d, input int x, input int y);
      return (fwd_pkt_width(a, d, x, y) - y) + 2 + (rev_pkt_width(d, x, y) - y) + 2;
   endfunction

endpackage

// File: rtl/bsg_manycore_ruche_x_edge_adapter_chan_buf.sv
// bsg_manycore_ruche_x_chan_buf: 2-entry elastic buffer, valid/ready on both sides.
// Upstream ready depends only on occupancy (and is held low while in reset).
module bsg_manycore_ruche_x_chan_buf
   import bsg_manycore_ruche_x_edge_adapter_pkg::*;
#(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i
);

   buf_state_e         state_q, state_d;
   logic               wptr_q, wptr_d;
   logic               rptr_q, rptr_d;
   logic [width_p-1:0] mem_q [2];
   logic               enq_s, deq_s;

   assign ready_o = (state_q != BUF_FULL) & ~reset_i;
   assign v_o     = (state_q != BUF_EMPTY);
   assign data_o  = mem_q[rptr_q];
   assign enq_s   = v_i & ready_o;
   assign deq_s   = v_o & ready_i;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q ^ enq_s;
      rptr_d  = rptr_q ^ deq_s;
      case (state_q)
         BUF_EMPTY: begin
            if (enq_s) state_d = BUF_ONE;
            else       state_d = BUF_EMPTY;
         end
         BUF_ONE: begin
            if (enq_s && !deq_s)      state_d = BUF_FULL;
            else if (!enq_s && deq_s) state_d = BUF_EMPTY;
            else                      state_d = BUF_ONE;
         end
         BUF_FULL: begin
            if (deq_s) state_d = BUF_ONE;
            else       state_d = BUF_FULL;
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= BUF_EMPTY;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   // storage needs no reset: contents are only visible while v_o is high
   always_ff @(posedge clk_i) begin
      if (enq_s) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/bsg_manycore_ruche_x_edge_adapter.sv
// Ruche-X lane-0 edge adapter: expands inbound compressed packets with my_y_i, strips y on outbound.
// Optional y-field checking is enabled by defining BSG_MANYCORE_RUCHE_X_Y_CHECK_EN.
module bsg_manycore_ruche_x_edge_adapter
   import bsg_manycore_ruche_x_edge_adapter_pkg::*;
#(
   parameter  int addr_width_p   = 28,
   parameter  int data_width_p   = 32,
   parameter  int x_cord_width_p = 6,
   parameter  int y_cord_width_p = 5,
   localparam int link_sif_width_lp =
      link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
   localparam int ruche_x_link_sif_width_lp =
      ruche_x_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [ruche_x_link_sif_width_lp-1:0] ruche_link_i,
   output logic [ruche_x_link_sif_width_lp-1:0] ruche_link_o,
   input  logic [link_sif_width_lp-1:0]         link_i,
   output logic [link_sif_width_lp-1:0]         link_o,
   input  logic [y_cord_width_p-1:0]            my_y_i,
   output logic                                 y_err_o
);

   localparam int YW  = y_cord_width_p;
   localparam int FW  = fwd_pkt_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
   localparam int RW  = rev_pkt_width(data_width_p, x_cord_width_p, y_cord_width_p);
   localparam int CFW = FW - YW;
   localparam int CRW = RW - YW;
   localparam int FY  = fwd_src_y_lsb(x_cord_width_p, y_cord_width_p);
   localparam int RY  = rev_dest_y_lsb(x_cord_width_p);
   localparam int RL  = RW + 2;
   localparam int CRL = CRW + 2;

   logic [CFW-1:0] ruche_fwd_s, f_out_wdata_s, f_out_data_s;
   logic [CRW-1:0] ruche_rev_s, r_out_wdata_s, r_out_data_s;
   logic [FW-1:0]  mesh_fwd_s, f_in_wdata_s, f_in_data_s;
   logic [RW-1:0]  mesh_rev_s, r_in_wdata_s, r_in_data_s;
   logic f_in_v_s, f_in_ready_s, f_out_v_s, f_out_ready_s;
   logic r_in_v_s, r_in_ready_s, r_out_v_s, r_out_ready_s;

   assign ruche_fwd_s = ruche_link_i[CRL+CFW:CRL+1];
   assign ruche_rev_s = ruche_link_i[CRW:1];
   assign mesh_fwd_s  = link_i[RL+FW:RL+1];
   assign mesh_rev_s  = link_i[RW:1];

   assign f_in_wdata_s  = {ruche_fwd_s[CFW-1:FY], my_y_i, ruche_fwd_s[FY-1:0]};
   assign f_out_wdata_s = {mesh_fwd_s[FW-1:FY+YW], mesh_fwd_s[FY-1:0]};
   assign r_in_wdata_s  = {ruche_rev_s[CRW-1:RY], my_y_i, ruche_rev_s[RY-1:0]};
   assign r_out_wdata_s = {mesh_rev_s[RW-1:RY+YW], mesh_rev_s[RY-1:0]};

   bsg_manycore_ruche_x_chan_buf #(.width_p(FW)) f_in_buf (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(ruche_link_i[CRL+CFW+1]), .data_i(f_in_wdata_s), .ready_o(f_in_ready_s),
      .v_o(f_in_v_s), .data_o(f_in_data_s), .ready_i(link_i[RL])
   );

   bsg_manycore_ruche_x_chan_buf #(.width_p(CFW)) f_out_buf (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(link_i[RL+FW+1]), .data_i(f_out_wdata_s), .ready_o(f_out_ready_s),
      .v_o(f_out_v_s), .data_o(f_out_data_s), .ready_i(ruche_link_i[CRL])
   );

   bsg_manycore_ruche_x_chan_buf #(.width_p(RW)) r_in_buf (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(ruche_link_i[CRW+1]), .data_i(r_in_wdata_s), .ready_o(r_in_ready_s),
      .v_o(r_in_v_s), .data_o(r_in_data_s), .ready_i(link_i[0])
   );

   bsg_manycore_ruche_x_chan_buf #(.width_p(CRW)) r_out_buf (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(link_i[RW+1]), .data_i(r_out_wdata_s), .ready_o(r_out_ready_s),
      .v_o(r_out_v_s), .data_o(r_out_data_s), .ready_i(ruche_link_i[0])
   );

   assign link_o       = {f_in_v_s, f_in_data_s, f_out_ready_s, r_in_v_s, r_in_data_s, r_out_ready_s};
   assign ruche_link_o = {f_out_v_s, f_out_data_s, f_in_ready_s, r_out_v_s, r_out_data_s, r_in_ready_s};

`ifdef BSG_MANYCORE_RUCHE_X_Y_CHECK_EN
   logic y_err_q, y_err_d;
   logic f_out_bad_s, r_out_bad_s;

   assign f_out_bad_s = link_i[RL+FW+1] & f_out_ready_s & (mesh_fwd_s[FY+:YW] != my_y_i);
   assign r_out_bad_s = link_i[RW+1] & r_out_ready_s & (mesh_rev_s[RY+:YW] != my_y_i);

   always_comb begin
      y_err_d = y_err_q | f_out_bad_s | r_out_bad_s;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) y_err_q <= 1'b0;
      else         y_err_q <= y_err_d;
   end

   assign y_err_o = y_err_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (f_out_bad_s) $error("F_OUT src_y=%0d my_y=%0d", mesh_fwd_s[FY+:YW], my_y_i);
      if (r_out_bad_s) $error("R_OUT dest_y=%0d my_y=%0d", mesh_rev_s[RY+:YW], my_y_i);
   end
`endif
`else
   // stripped y fields are intentionally dropped when checking is disabled
   logic unused_y_s;
   assign unused_y_s = ^{mesh_fwd_s[FY+:YW], mesh_rev_s[RY+:YW]};
   assign y_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_ruche_x_edge_adapter.sv
// Scoreboard bench for the ruche-X edge adapter: field-level packet model, randomized traffic.
module tb_bsg_manycore_ruche_x_edge_adapter;

   localparam int AW  = 28, DW = 32, XW = 6, YW = 5;
   localparam int UPF = AW + DW + 9;         // fwd bits above the coordinate fields
   localparam int UPR = DW + 7;              // rev bits above the coordinate fields
   localparam int FW  = UPF + 2*XW + 2*YW;
   localparam int RW  = UPR + XW + YW;
   localparam int CFW = FW - YW;
   localparam int CRW = RW - YW;
   localparam int LW  = FW + RW + 4;
   localparam int RLW = CFW + CRW + 4;
   localparam logic [YW-1:0] MY_Y = 5'd3;
`ifdef BSG_MANYCORE_RUCHE_X_Y_CHECK_EN
   localparam bit YCHK = 1'b1;
`else
   localparam bit YCHK = 1'b0;
`endif

   logic           clk, rst;
   logic [RLW-1:0] ruche_link_i, ruche_link_o;
   logic [LW-1:0]  link_i, link_o;
   logic           y_err;

   // channel index: 0 F_IN, 1 F_OUT, 2 R_IN, 3 R_OUT
   logic [3:0]    drv_v, cur_v, ds, ov, ir;
   logic [FW-1:0] drv_in [4];
   logic [FW-1:0] cur_in [4];
   logic [FW-1:0] cur_exp[4];
   logic [YW-1:0] cur_y  [4];
   logic [FW-1:0] od     [4];
   logic [FW-1:0] sb0[$], sb1[$], sb2[$], sb3[$];
   int checks, failures;
   int push_cnt[4], deq_cnt[4];
   logic yerr_exp;

   bsg_manycore_ruche_x_edge_adapter #(
      .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .ruche_link_i(ruche_link_i), .ruche_link_o(ruche_link_o),
      .link_i(link_i), .link_o(link_o),
      .my_y_i(MY_Y), .y_err_o(y_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ruche_link_i = {drv_v[0], drv_in[0][CFW-1:0], ds[1], drv_v[2], drv_in[2][CRW-1:0], ds[3]};
   assign link_i       = {drv_v[1], drv_in[1], ds[0], drv_v[3], drv_in[3][RW-1:0], ds[2]};
   assign ov = {ruche_link_o[CRW+1], link_o[RW+1], ruche_link_o[RLW-1], link_o[LW-1]};
   assign ir = {link_o[0], ruche_link_o[0], link_o[RW+2], ruche_link_o[CRW+2]};
   assign od[0] = link_o[LW-2 -: FW];
   assign od[1] = {{YW{1'b0}}, ruche_link_o[RLW-2 -: CFW]};
   assign od[2] = {{(FW-RW){1'b0}}, link_o[RW:1]};
   assign od[3] = {{(FW-CRW){1'b0}}, ruche_link_o[CRW:1]};

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Builds one packet on a channel from its fields; the model is plain field concatenation.
   task automatic load_fields(input int ch, input logic [UPF-1:0] up, input logic [YW-1:0] y,
                              input logic [XW-1:0] sx, input logic [YW-1:0] dy, input logic [XW-1:0] dx);
      cur_in[ch]  = '0;
      cur_exp[ch] = '0;
      cur_y[ch]   = y;
      case (ch)
         0: begin
            cur_in[ch][CFW-1:0] = {up, sx, dy, dx};
            cur_exp[ch]         = {up, MY_Y, sx, dy, dx};
         end
         1: begin
            cur_in[ch]           = {up, y, sx, dy, dx};
            cur_exp[ch][CFW-1:0] = {up, sx, dy, dx};
         end
         2: begin
            cur_in[ch][CRW-1:0] = {up[UPR-1:0], dx};
            cur_exp[ch][RW-1:0] = {up[UPR-1:0], MY_Y, dx};
         end
         default: begin
            cur_in[ch][RW-1:0]    = {up[UPR-1:0], y, dx};
            cur_exp[ch][CRW-1:0]  = {up[UPR-1:0], dx};
         end
      endcase
      cur_v[ch] = 1'b1;
   endtask

   task automatic load(input int ch, input logic [YW-1:0] y);
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      load_fields(ch, r[UPF-1:0], y, r[UPF+XW-1:UPF], r[UPF+XW+YW-1:UPF+XW], r[UPF+2*XW+YW-1:UPF+XW+YW]);
   endtask

   function automatic logic [YW-1:0] rand_y();
      logic [31:0] r;
      r = $urandom;
      return YCHK ? MY_Y : r[YW-1:0];
   endfunction

   task automatic push(input int ch, input logic [FW-1:0] v);
      push_cnt[ch]++;
      case (ch)
         0: sb0.push_back(v);
         1: sb1.push_back(v);
         2: sb2.push_back(v);
         default: sb3.push_back(v);
      endcase
   endtask

   task automatic apply();
      drv_v = cur_v;
      for (int ch = 0; ch < 4; ch++) drv_in[ch] = cur_in[ch];
   endtask

   task automatic accept();
      for (int ch = 0; ch < 4; ch++) begin
         if (cur_v[ch] && ir[ch]) begin
            push(ch, cur_exp[ch]);
            if (YCHK && (ch == 1 || ch == 3) && cur_y[ch] != MY_Y) yerr_exp = 1'b1;
            cur_v[ch] = 1'b0;
         end
      end
   endtask

   task automatic half_a();
      apply();
      @(negedge clk);
      chk_i("y_err", int'(y_err), int'(yerr_exp));
   endtask

   task automatic half_b();
      accept();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      half_a();
      half_b();
   endtask

   task automatic mon_pop(input int ch);
      logic [FW-1:0] e;
      int n;
      deq_cnt[ch]++;
      case (ch)
         0: n = sb0.size();
         1: n = sb1.size();
         2: n = sb2.size();
         default: n = sb3.size();
      endcase
      if (n == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_out ch%0d actual=%h expected=none", ch, od[ch]);
      end else begin
         case (ch)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            2: e = sb2.pop_front();
            default: e = sb3.pop_front();
         endcase
         chk($sformatf("data_ch%0d", ch), od[ch], e);
      end
   endtask

   // monitor: every output handshake is matched against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (ov[ch] && ds[ch]) mon_pop(ch);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int sent;
      rst = 1'b1; cur_v = '0; ds = '0; drv_v = '0; yerr_exp = 1'b0;
      checks = 0; failures = 0;
      for (int ch = 0; ch < 4; ch++) begin
         cur_in[ch] = '0; cur_exp[ch] = '0; cur_y[ch] = '0; drv_in[ch] = '0;
         push_cnt[ch] = 0; deq_cnt[ch] = 0;
      end

      // reset state
      repeat (2) @(negedge clk);
      chk_i("rst_v", int'(ov), 0);
      chk_i("rst_ready", int'(ir), 0);
      chk_i("rst_y_err", int'(y_err), 0);
      @(posedge clk); #1;
      rst = 1'b0; ds = 4'hF;
      @(negedge clk);
      chk_i("post_rst_ready", int'(ir), 15);
      chk_i("post_rst_v", int'(ov), 0);
      @(posedge clk); #1;

      // F_IN single directed packet
      load_fields(0, {28'h0A5A5A5, 9'h000, 32'hDEADBEEF}, MY_Y, 6'd9, 5'd3, 6'd2);
      half_a();
      chk_i("fin_v_at_enq", int'(ov[0]), 0);
      half_b();
      half_a();
      chk_i("fin_v_next", int'(ov[0]), 1);
      chk("fin_pkt", od[0], {28'h0A5A5A5, 9'h000, 32'hDEADBEEF, 5'd3, 6'd9, 5'd3, 6'd2});
      half_b();
      tick();

      // backpressure on F_IN
      ds[0] = 1'b0;
      sent = 0;
      for (int c = 0; c < 6; c++) begin
         if (!cur_v[0] && sent < 3) begin load(0, MY_Y); sent++; end
         half_a();
         if (c >= 2) chk_i("bp_ready_low", int'(ir[0]), 0);
         half_b();
      end
      ds[0] = 1'b1;
      half_a();
      chk_i("bp_ready_at_release", int'(ir[0]), 0);
      half_b();
      half_a();
      chk_i("bp_ready_after_deq", int'(ir[0]), 1);
      half_b();
      chk_i("bp_third_accepted", int'(cur_v[0]), 0);
      repeat (3) tick();

      // full rate on all channels concurrently (R_OUT strips dest_y=3)
      ds = 4'hF;
      for (int c = 0; c < 9; c++) begin
         if (c < 8) for (int ch = 0; ch < 4; ch++) load(ch, MY_Y);
         half_a();
         if (c < 8)  chk_i("fr_ready", int'(ir), 15);
         if (c >= 1) chk_i("fr_valid", int'(ov), 15);
         half_b();
      end
      half_a();
      chk_i("fr_drained", int'(ov), 0);
      half_b();

      // F_OUT with mismatching src_y is still forwarded
      load(1, 5'd4);
      repeat (3) tick();

      // reset with F_IN full
      ds = 4'h0;
      load(0, MY_Y); tick();
      load(0, MY_Y); tick();
      rst = 1'b1;
      #1;
      chk_i("rst_mid_v", int'(ov), 0);
      chk_i("rst_mid_ready", int'(ir), 0);
      sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
      for (int ch = 0; ch < 4; ch++) begin push_cnt[ch] = 0; deq_cnt[ch] = 0; end
      cur_v = '0; yerr_exp = 1'b0;
      apply();
      @(posedge clk); #1;
      rst = 1'b0; ds = 4'hF;
      for (int c = 0; c < 4; c++) begin
         half_a();
         chk_i("rst_no_stale", int'(ov), 0);
         chk_i("rst_ready_back", int'(ir), 15);
         half_b();
      end

      // randomized traffic with random downstream stalls
      for (int c = 0; c < 600; c++) begin
         ds = 4'($urandom);
         for (int ch = 0; ch < 4; ch++)
            if (!cur_v[ch] && $urandom_range(0, 99) < 60) load(ch, rand_y());
         tick();
      end
      ds = 4'hF;
      for (int c = 0; c < 10; c++) tick();
      chk_i("drain_pending", int'(cur_v), 0);
      chk_i("drain_sb0", sb0.size(), 0);
      chk_i("drain_sb1", sb1.size(), 0);
      chk_i("drain_sb2", sb2.size(), 0);
      chk_i("drain_sb3", sb3.size(), 0);
      for (int ch = 0; ch < 4; ch++)
         chk_i($sformatf("count_ch%0d", ch), deq_cnt[ch], push_cnt[ch]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_ruche_x_edge_adapter.md
# bsg_manycore_ruche_x_edge_adapter

Terminates one ruche-X lane (lane 0) at the east or west edge of a ruche tile row and converts it to a full manycore mesh link. Ruche-X traffic runs in compressed form: fwd packets omit src_y and rev packets omit dest_y. This block performs the matching edge conversion and buffers every channel in a 2-entry elastic buffer:
- inbound packets are expanded with the row's `my_y_i`;
- outbound packets are compressed by stripping the y field.

## Interface
- `addr_width_p`, "inv": manycore packet address width.
- `data_width_p`, "inv": manycore packet data width.
- `x_cord_width_p`, "inv": x coordinate width.
- `y_cord_width_p`, "inv": y coordinate width.
- `link_sif_width_lp`, derived: `` `bsg_manycore_link_sif_width ``(addr,data,x,y).
- `ruche_x_link_sif_width_lp`, derived: `` `bsg_manycore_ruche_x_link_sif_width ``(addr,data,x,y).
- `clk_i` in 1: sole clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `ruche_link_i` in `ruche_x_link_sif_width_lp`: compressed link from the ruche row.
- `ruche_link_o` out `ruche_x_link_sif_width_lp`: compressed link to the ruche row.
- `link_i` in `link_sif_width_lp`: full mesh link from the edge client.
- `link_o` out `link_sif_width_lp`: full mesh link to the edge client.
- `my_y_i` in `y_cord_width_p`: row y coordinate; quasi-static.
- `y_err_o` out 1: sticky y-field mismatch flag (see Configuration).

## Operation
- There are four independent channels. Each channel has its own buffer:
  - F_IN: `ruche_link_i.fwd` → `link_o.fwd`. Insert `my_y_i` as src_y at bit `2x+y`; bits below stay; bits above shift up by y.
  - F_OUT: `link_i.fwd` → `ruche_link_o.fwd`. Remove bits `[2x+2y-1:2x+y]` (src_y).
  - R_IN: `ruche_link_i.rev` → `link_o.rev`. Insert `my_y_i` as dest_y at bit `x`.
  - R_OUT: `link_i.rev` → `ruche_link_o.rev`. Remove bits `[x+y-1:x]` (dest_y).
- The transform is applied at enqueue. Buffers store the output-format packet, and `my_y_i` is sampled at enqueue.
- Handshake is valid/ready-and on every channel:
  - Enqueue occurs when `v` is high and this block's `ready_and_rev` is high.
  - Dequeue occurs when output `v` is high and the downstream `ready_and_rev` is high.
  - Upstream `ready_and_rev` depends only on buffer state, never on downstream ready in the same cycle.
- Buffer state machine per channel: EMPTY(0) / ONE(1) / FULL(2).
  - EMPTY: `ready`=1, `v_o`=0. Enqueue → ONE.
  - ONE: `ready`=1, `v_o`=1. Enqueue only → FULL. Dequeue only → EMPTY. Both → ONE.
  - FULL: `ready`=0, `v_o`=1. Dequeue → ONE. Enqueue is impossible because ready is low.
- Read and write pointers are 1 bit and wrap modulo 2.
- Packets on a channel are delivered in order. No drops, no duplication.
- Reset (async assert, any state):
  - All buffers go to EMPTY.
  - Every output `v` = 0 and every `ready_and_rev` = 1 after deassert; during reset, ready is driven 0.
  - `y_err_o` = 0.
  - Stored data is don't-care.
- Reset mid-transfer discards buffered packets.

## Timing
- Latency from enqueue to output valid is 1 cycle.
- Sustained throughput is 1 packet/cycle/channel while downstream is ready.
- Output data and valid come straight from buffer registers. No combinational path runs from `*_i` data to `*_o` data.
- The only combinational path from `my_y_i` is into the buffer write data.
- Reset deassert must be synchronized externally. The first enqueue may occur on the first rising edge after deassert.

## Configuration
- `BSG_MANYCORE_RUCHE_X_Y_CHECK_EN`.
- Defined:
  - On each F_OUT enqueue where the stripped src_y ≠ `my_y_i`, or each R_OUT enqueue where the stripped dest_y ≠ `my_y_i`, `y_err_o` sets on the next edge and stays set until reset.
  - Each such event also issues `$error` in simulation with the channel name and values.
- Undefined: `y_err_o` is tied 0 and no comparison logic exists.
- Packet behaviour is identical either way. Mismatching packets are still forwarded.

## Structure
- `bsg_manycore_pkg` holds:
  - the existing fwd/rev packet and ruche_x packet typedefs and link_sif declare macros;
  - new localparam helpers for the y-field bit offsets of fwd (`2x+y`) and rev (`x`).
- One sub-module, `bsg_manycore_ruche_x_chan_buf`:
  - parameters: `width_p`;
  - contents: a 2-entry async-reset buffer with valid/ready on both sides;
  - instantiated 4× with the transform logic placed outside it.

## Test plan
Configuration: x=6, y=5, data=32, addr=28, `my_y_i`=5'd3.
- Reset mid-burst: assert reset with F_IN FULL. → All output `v`=0 immediately. After deassert, `ready`=1, `y_err_o`=0, and no stale packet emerges.
- F_IN single packet: dest_x=2, dest_y=3, src_x=9, payload 0xDEADBEEF. → One cycle later `link_o.fwd` shows src_y=3 and all other fields bit-identical.
- Backpressure: hold `link_o` ready=0 and offer 3 F_IN packets. → Ready drops after 2 accepts. Release ready → all 3 arrive in order, with the third accepted the cycle after the first dequeue.
- R_OUT strip at full rate: 8 back-to-back rev packets with dest_y=3 and ready always high. → `ruche_link_o.rev` carries 8 packets on consecutive cycles with dest_y removed and dest_x intact.
- Simultaneous enq/deq in ONE: occurs on all 4 channels concurrently. → Every channel stays in ONE, with no bubble or loss.
- Check macro defined: F_OUT packet with src_y=4. → `y_err_o`=1 next cycle, stays 1, and the packet is still forwarded. With the macro undefined, `y_err_o`=0.
